// File: rtl/pong_datapath.sv
// Pong datapath: owns paddle/ball positions, movement and collision, and
// drives the zero-latency pixel stream while the control FSM holds a draw strobe.
module pong_datapath #(
   parameter int         SCREEN_W    = 160,
   parameter int         SCREEN_H    = 120,
   parameter int         PAD_W       = 2,
   parameter int         PAD_H       = 16,
   parameter int         BALL_SIZE   = 4,
   parameter int         LEFT_PAD_X  = 4,
   parameter int         RIGHT_PAD_X = 154,
   parameter int         PAD_STEP    = 2,
   parameter logic [2:0] PAD_COLOUR  = 3'b111,
   parameter logic [2:0] BALL_COLOUR = 3'b110,
   parameter logic [2:0] BG_COLOUR   = 3'b000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       menu,
   input  logic       move_pads,
   input  logic       move_ball,
   input  logic       clear_screen,
   input  logic       load_left_pad,
   input  logic       draw_left_pad,
   input  logic       load_right_pad,
   input  logic       draw_right_pad,
   input  logic       load_ball,
   input  logic       draw_ball,
   input  logic       reset_delta,
   input  logic       left_up,
   input  logic       left_down,
   input  logic       right_up,
   input  logic       right_down,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       gameover
);
   localparam logic [6:0] PAD_Y_MAX  = 7'(SCREEN_H - PAD_H);
   localparam logic [6:0] PAD_Y_RST  = 7'((SCREEN_H - PAD_H) / 2);
   localparam logic [7:0] BALL_X_RST = 8'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [6:0] BALL_Y_RST = 7'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [6:0] STEP       = 7'(PAD_STEP);

   logic [6:0] pad_l_q, pad_l_d, pad_r_q, pad_r_d;
   logic [7:0] ball_x_q, ball_x_d;
   logic [6:0] ball_y_q, ball_y_d;
   logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;   // 1 = right / down
   logic [7:0] org_x_q, org_x_d;
   logic [6:0] org_y_q, org_y_d;
   logic [2:0] col_q, col_d;
   logic [3:0] off_x_q, off_x_d, off_y_q, off_y_d;
   logic [7:0] clr_x_q, clr_x_d;
   logic [6:0] clr_y_q, clr_y_d;

   logic [7:0] ball_bot_s;
   logic [8:0] ball_rgt_s;
   logic       overlap_l_s, overlap_r_s;
   logic       dir_x_s, dir_y_s, at_edge_s;
   logic       draw_pad_s, draw_any_s;
   logic [3:0] shape_w_m1_s, shape_h_m1_s;

   function automatic logic [6:0] pad_move(input logic [6:0] pos, input logic up, input logic dn);
      logic [6:0] res;
      if (up && !dn) begin
         res = (pos < STEP) ? 7'd0 : pos - STEP;
      end else if (dn && !up) begin
         res = (pos > PAD_Y_MAX - STEP) ? PAD_Y_MAX : pos + STEP;
      end else begin
         res = pos;
      end
      return res;
   endfunction

   assign ball_bot_s  = {1'b0, ball_y_q} + 8'(BALL_SIZE);
   assign ball_rgt_s  = {1'b0, ball_x_q} + 9'(BALL_SIZE);
   assign overlap_l_s = (ball_bot_s > {1'b0, pad_l_q}) &&
                        ({1'b0, ball_y_q} < ({1'b0, pad_l_q} + 8'(PAD_H)));
   assign overlap_r_s = (ball_bot_s > {1'b0, pad_r_q}) &&
                        ({1'b0, ball_y_q} < ({1'b0, pad_r_q} + 8'(PAD_H)));
   assign gameover    = (!dir_x_q && (ball_x_q == 8'd0)) ||
                        (dir_x_q && (ball_rgt_s == 9'(SCREEN_W)));

   // Ball direction after wall and paddle reflection; at_edge pins x at an outer edge.
   always_comb begin
      if (dir_y_q && (ball_bot_s == 8'(SCREEN_H))) begin
         dir_y_s = 1'b0;
      end else if (!dir_y_q && (ball_y_q == 7'd0)) begin
         dir_y_s = 1'b1;
      end else begin
         dir_y_s = dir_y_q;
      end
      if (!dir_x_q && (ball_x_q == 8'(LEFT_PAD_X + PAD_W)) && overlap_l_s) begin
         dir_x_s = 1'b1;
      end else if (dir_x_q && (ball_rgt_s == 9'(RIGHT_PAD_X)) && overlap_r_s) begin
         dir_x_s = 1'b0;
      end else begin
         dir_x_s = dir_x_q;
      end
      at_edge_s = (!dir_x_s && (ball_x_q == 8'd0)) ||
                  (dir_x_s && (ball_rgt_s == 9'(SCREEN_W)));
   end

   // Game-state next values: one update per cycle, menu > move_ball > move_pads > load.
   always_comb begin
      pad_l_d  = pad_l_q;
      pad_r_d  = pad_r_q;
      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      org_x_d  = org_x_q;
      org_y_d  = org_y_q;
      col_d    = col_q;
      if (menu) begin
         pad_l_d  = PAD_Y_RST;
         pad_r_d  = PAD_Y_RST;
         ball_x_d = BALL_X_RST;
         ball_y_d = BALL_Y_RST;
         dir_x_d  = 1'b1;
         dir_y_d  = 1'b1;
      end else if (move_ball) begin
         dir_y_d  = dir_y_s;
         dir_x_d  = dir_x_s;
         ball_y_d = dir_y_s ? ball_y_q + 7'd1 : ball_y_q - 7'd1;
         if (at_edge_s) begin
            ball_x_d = ball_x_q;
         end else begin
            ball_x_d = dir_x_s ? ball_x_q + 8'd1 : ball_x_q - 8'd1;
         end
      end else if (move_pads) begin
         pad_l_d = pad_move(pad_l_q, left_up, left_down);
         pad_r_d = pad_move(pad_r_q, right_up, right_down);
      end else if (load_left_pad) begin
         org_x_d = 8'(LEFT_PAD_X);
         org_y_d = pad_l_q;
         col_d   = PAD_COLOUR;
      end else if (load_right_pad) begin
         org_x_d = 8'(RIGHT_PAD_X);
         org_y_d = pad_r_q;
         col_d   = PAD_COLOUR;
      end else if (load_ball) begin
         org_x_d = ball_x_q;
         org_y_d = ball_y_q;
         col_d   = BALL_COLOUR;
      end else begin
         col_d = col_q;
      end
   end

   assign draw_pad_s   = draw_left_pad || draw_right_pad;
   assign draw_any_s   = draw_pad_s || draw_ball;
   assign shape_w_m1_s = draw_pad_s ? 4'(PAD_W - 1) : 4'(BALL_SIZE - 1);
   assign shape_h_m1_s = draw_pad_s ? 4'(PAD_H - 1) : 4'(BALL_SIZE - 1);

   // Sweep counters: clear raster and shape offsets, both row-major with wrap.
   always_comb begin
      off_x_d = off_x_q;
      off_y_d = off_y_q;
      clr_x_d = clr_x_q;
      clr_y_d = clr_y_q;
      if (reset_delta) begin
         off_x_d = 4'd0;
         off_y_d = 4'd0;
         clr_x_d = 8'd0;
         clr_y_d = 7'd0;
      end else if (clear_screen) begin
         if (clr_x_q == 8'(SCREEN_W - 1)) begin
            clr_x_d = 8'd0;
            clr_y_d = (clr_y_q == 7'(SCREEN_H - 1)) ? 7'd0 : clr_y_q + 7'd1;
         end else begin
            clr_x_d = clr_x_q + 8'd1;
         end
      end else if (draw_any_s) begin
         if (off_x_q == shape_w_m1_s) begin
            off_x_d = 4'd0;
            off_y_d = (off_y_q == shape_h_m1_s) ? 4'd0 : off_y_q + 4'd1;
         end else begin
            off_x_d = off_x_q + 4'd1;
         end
      end else begin
         off_x_d = off_x_q;
      end
   end

   // Pixel stream is combinational so the adapter captures it on the plot edge.
   always_comb begin
      if (clear_screen) begin
         x      = clr_x_q;
         y      = clr_y_q;
         colour = BG_COLOUR;
      end else if (draw_any_s) begin
         x      = org_x_q + {4'd0, off_x_q};
         y      = org_y_q + {3'd0, off_y_q};
         colour = col_q;
      end else begin
         x      = org_x_q + {4'd0, off_x_q};
         y      = org_y_q + {3'd0, off_y_q};
         colour = BG_COLOUR;
      end
   end

   // State registers with asynchronous reset to the menu position.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pad_l_q  <= PAD_Y_RST;
         pad_r_q  <= PAD_Y_RST;
         ball_x_q <= BALL_X_RST;
         ball_y_q <= BALL_Y_RST;
         dir_x_q  <= 1'b1;
         dir_y_q  <= 1'b1;
         org_x_q  <= 8'd0;
         org_y_q  <= 7'd0;
         col_q    <= BG_COLOUR;
         off_x_q  <= 4'd0;
         off_y_q  <= 4'd0;
         clr_x_q  <= 8'd0;
         clr_y_q  <= 7'd0;
      end else begin
         pad_l_q  <= pad_l_d;
         pad_r_q  <= pad_r_d;
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         org_x_q  <= org_x_d;
         org_y_q  <= org_y_d;
         col_q    <= col_d;
         off_x_q  <= off_x_d;
         off_y_q  <= off_y_d;
         clr_x_q  <= clr_x_d;
         clr_y_q  <= clr_y_d;
      end
   end
endmodule

// File: tb/tb_pong_datapath.sv
// Bench for pong_datapath: behavioural game/raster model compared every cycle,
// randomized strobes and keys, plus hand-computed literal checkpoints.
module tb_pong_datapath;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [10:0] st = 11'd0;
   logic [3:0]  keys = 4'd0;
   logic        menu, move_pads, move_ball, clear_screen, load_left_pad, draw_left_pad;
   logic        load_right_pad, draw_right_pad, load_ball, draw_ball, reset_delta;
   logic        left_up, left_down, right_up, right_down;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        gameover;
   logic        cmp_en = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   localparam logic [10:0] S_MENU = 11'h001, S_PADS = 11'h002, S_BALL = 11'h004;
   localparam logic [10:0] S_CLR  = 11'h008, S_LDL  = 11'h010, S_DRL  = 11'h020;
   localparam logic [10:0] S_LDR  = 11'h040, S_DRR  = 11'h080, S_LDB  = 11'h100;
   localparam logic [10:0] S_DRB  = 11'h200, S_RD   = 11'h400;

   assign {reset_delta, draw_ball, load_ball, draw_right_pad, load_right_pad,
           draw_left_pad, load_left_pad, clear_screen, move_ball, move_pads, menu} = st;
   assign {left_up, left_down, right_up, right_down} = keys;

   always #5 clk = ~clk;

   pong_datapath dut (
      .clk(clk), .resetn(resetn), .menu(menu), .move_pads(move_pads), .move_ball(move_ball),
      .clear_screen(clear_screen), .load_left_pad(load_left_pad), .draw_left_pad(draw_left_pad),
      .load_right_pad(load_right_pad), .draw_right_pad(draw_right_pad), .load_ball(load_ball),
      .draw_ball(draw_ball), .reset_delta(reset_delta), .left_up(left_up), .left_down(left_down),
      .right_up(right_up), .right_down(right_down), .x(x), .y(y), .colour(colour),
      .gameover(gameover)
   );

   // Reference model: positions as plain integers, raster progress as a pixel index.
   int m_pl, m_pr, m_bx, m_by, m_ox, m_oy, m_col, m_k, m_kc;
   bit m_dx, m_dy;

   function automatic void m_reset_pos();
      m_pl = 52; m_pr = 52; m_bx = 78; m_by = 58; m_dx = 1'b1; m_dy = 1'b1;
   endfunction

   function automatic void m_hard_reset();
      m_reset_pos();
      m_ox = 0; m_oy = 0; m_col = 0; m_k = 0; m_kc = 0;
   endfunction

   function automatic bit m_gameover();
      return (!m_dx && m_bx == 0) || (m_dx && m_bx + 4 == 160);
   endfunction

   function automatic int m_pad(input int p, input bit up, input bit dn);
      if (up && !dn) return (p - 2 < 0) ? 0 : p - 2;
      if (dn && !up) return (p + 2 > 104) ? 104 : p + 2;
      return p;
   endfunction

   function automatic void m_move_ball();
      bit hit_l, hit_r;
      hit_l = !m_dx && m_bx == 6   && (m_by + 4 > m_pl) && (m_by < m_pl + 16);
      hit_r =  m_dx && m_bx == 150 && (m_by + 4 > m_pr) && (m_by < m_pr + 16);
      if (m_dy && m_by == 116) m_dy = 1'b0;
      else if (!m_dy && m_by == 0) m_dy = 1'b1;
      m_by = m_dy ? m_by + 1 : m_by - 1;
      if (hit_l) m_dx = 1'b1;
      if (hit_r) m_dx = 1'b0;
      if (!m_gameover()) m_bx = m_dx ? m_bx + 1 : m_bx - 1;
   endfunction

   function automatic void m_step();
      bit dp = st[5] || st[7];
      bit db = st[9];
      int area = dp ? 32 : 16;
      if (st[0]) m_reset_pos();
      else if (st[2]) m_move_ball();
      else if (st[1]) begin
         m_pl = m_pad(m_pl, keys[3], keys[2]);
         m_pr = m_pad(m_pr, keys[1], keys[0]);
      end
      else if (st[4]) begin m_ox = 4;    m_oy = m_pl; m_col = 7; end
      else if (st[6]) begin m_ox = 154;  m_oy = m_pr; m_col = 7; end
      else if (st[8]) begin m_ox = m_bx; m_oy = m_by; m_col = 6; end
      if (st[10]) begin m_k = 0; m_kc = 0; end
      else if (st[3]) m_kc = (m_kc + 1) % 19200;
      else if (dp || db) m_k = (m_k + 1) % area;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model advance on each active edge (or asynchronous reset).
   initial begin
      m_hard_reset();
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) m_hard_reset();
         else m_step();
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      int w;
      forever begin
         @(negedge clk);
         #2;
         if (cmp_en && resetn) begin
            check("gameover", int'(gameover), int'(m_gameover()));
            if (clear_screen) begin
               check("clr_x", int'(x), m_kc % 160);
               check("clr_y", int'(y), m_kc / 160);
               check("clr_colour", int'(colour), 0);
            end else if (draw_left_pad || draw_right_pad || draw_ball) begin
               w = (draw_left_pad || draw_right_pad) ? 2 : 4;
               check("draw_x", int'(x), m_ox + m_k % w);
               check("draw_y", int'(y), m_oy + m_k / w);
               check("draw_colour", int'(colour), m_col);
            end else begin
               check("idle_colour", int'(colour), 0);
            end
         end
      end
   end

   task automatic cyc(input logic [10:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         st = s;
         @(negedge clk);
      end
      st = 11'd0;
   endtask

   task automatic lit_first(input string name, input logic [10:0] ld, input logic [10:0] dr,
                            input int ex, input int ey, input int ec);
      cyc(S_RD, 1);
      cyc(ld, 1);
      st = dr;
      #3;
      check({name, "_x"}, int'(x), ex);
      check({name, "_y"}, int'(y), ey);
      check({name, "_c"}, int'(colour), ec);
      @(negedge clk);
      st = 11'd0;
   endtask

   initial begin
      logic [10:0] lds [3];
      logic [10:0] drs [3];
      int r, sel;
      lds[0] = S_LDL; lds[1] = S_LDR; lds[2] = S_LDB;
      drs[0] = S_DRL; drs[1] = S_DRR; drs[2] = S_DRB;

      repeat (2) @(negedge clk);
      resetn = 1'b1;
      cmp_en = 1'b1;
      #3;
      check("rst_x", int'(x), 0);
      check("rst_y", int'(y), 0);
      check("rst_colour", int'(colour), 0);
      check("rst_gameover", int'(gameover), 0);
      @(negedge clk);
      cyc(S_MENU, 1);
      lit_first("menu_ball", S_LDB, S_DRB, 78, 58, 6);
      lit_first("menu_padl", S_LDL, S_DRL, 4, 52, 7);
      lit_first("menu_padr", S_LDR, S_DRR, 154, 52, 7);

      // Paddle stream: 32 pixels then wrap to the origin.
      cyc(S_RD, 1);
      cyc(S_LDL, 1);
      for (int k = 0; k < 33; k++) begin
         st = S_DRL;
         #3;
         check("stream_x", int'(x), 4 + k % 2);
         check("stream_y", int'(y), 52 + (k / 2) % 16);
         @(negedge clk);
      end
      st = 11'd0;

      // Saturation at the top and both-keys hold.
      keys = 4'b1000;
      cyc(S_PADS, 30);
      keys = 4'b0011;
      cyc(S_PADS, 5);
      keys = 4'b0000;
      lit_first("sat_padl", S_LDL, S_DRL, 4, 0, 7);
      lit_first("hold_padr", S_LDR, S_DRR, 154, 52, 7);

      // Wall bounce then a right-side miss with the right paddle parked at the top.
      cyc(S_MENU, 1);
      keys = 4'b0010;
      cyc(S_PADS, 26);
      keys = 4'b0000;
      cyc(S_BALL, 58);
      lit_first("pre_bounce", S_LDB, S_DRB, 136, 116, 6);
      cyc(S_BALL, 1);
      lit_first("post_bounce", S_LDB, S_DRB, 137, 115, 6);
      cyc(S_BALL, 19);
      #3;
      check("gameover_lit", int'(gameover), 1);
      @(negedge clk);
      cyc(S_BALL, 1);
      lit_first("edge_hold", S_LDB, S_DRB, 156, 95, 6);
      cyc(S_MENU, 1);
      #3;
      check("gameover_clr", int'(gameover), 0);
      @(negedge clk);

      // Full clear sweep plus one wrap cycle.
      cyc(S_RD, 1);
      for (int k = 0; k <= 19200; k++) begin
         st = S_CLR;
         if (k == 159 || k == 160 || k == 19199 || k == 19200) begin
            #3;
            check("sweep_x", int'(x), (k == 159 || k == 19199) ? 159 : 0);
            check("sweep_y", int'(y), (k == 160) ? 1 : ((k == 19199) ? 119 : 0));
         end
         @(negedge clk);
      end
      st = 11'd0;

      // Randomized play.
      for (int i = 0; i < 2500; i++) begin
         r = $urandom_range(0, 999);
         keys = 4'($urandom);
         if (r < 6) cyc(S_MENU, 1);
         else if (r < 450) cyc(S_BALL, 1);
         else if (r < 650) cyc(S_PADS, 1);
         else if (r < 850) begin
            sel = $urandom_range(0, 2);
            cyc(S_RD, 1);
            cyc(lds[sel], 1);
            cyc(drs[sel], $urandom_range(1, 40));
         end
         else if (r < 890) begin
            cyc(S_RD, 1);
            cyc(S_CLR, $urandom_range(1, 100));
         end
         else if (r < 950) cyc(11'($urandom) & 11'h157, 1);
         else cyc(11'd0, 1);
      end

      // Asynchronous reset in the middle of a ball draw.
      cyc(S_MENU, 1);
      cyc(S_RD, 1);
      cyc(S_LDB, 1);
      cyc(S_DRB, 5);
      st = S_DRB;
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("async_x", int'(x), 0);
      check("async_y", int'(y), 0);
      check("async_colour", int'(colour), 0);
      @(negedge clk);
      st = 11'd0;
      @(negedge clk);
      resetn = 1'b1;
      cyc(S_MENU, 1);
      lit_first("post_rst_ball", S_LDB, S_DRB, 78, 58, 6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pong_datapath.md
Name: pong_datapath

Overview:
- Datapath companion to the Pong control FSM. Consumes its one-hot state strobes: menu, move, load, draw, clear, reset_delta and plot.
- Owns paddle and ball positions, performs movement and collision, and raises gameover.
- Generates the per-cycle pixel x/y/colour stream for the VGA adapter while the FSM holds plot high.

Parameters:
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
PAD_W, 2, paddle width
PAD_H, 16, paddle height (PAD_W*PAD_H = 32 pixels per paddle draw)
BALL_SIZE, 4, ball edge length (square)
LEFT_PAD_X, 4, left paddle column origin
RIGHT_PAD_X, 154, right paddle column origin
PAD_STEP, 2, paddle pixels moved per move_pads pulse
PAD_COLOUR, 3'b111, paddle colour
BALL_COLOUR, 3'b110, ball colour
BG_COLOUR, 3'b000, clear colour

Ports:
clk  in  1  system clock, sole clock
resetn  in  1  asynchronous active-low reset
menu  in  1  FSM in menu state
move_pads  in  1  one-cycle paddle update strobe
move_ball  in  1  one-cycle ball update strobe
clear_screen  in  1  clear sweep active
load_left_pad  in  1  latch left paddle origin
draw_left_pad  in  1  left paddle draw active
load_right_pad  in  1  latch right paddle origin
draw_right_pad  in  1  right paddle draw active
load_ball  in  1  latch ball origin
draw_ball  in  1  ball draw active
reset_delta  in  1  zero draw/clear offset counters
left_up, left_down, right_up, right_down  in  1 each  keyboard levels
x  out  8  pixel column
y  out  7  pixel row
colour  out  3  pixel colour
gameover  out  1  ball at outer edge moving outward

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous and active-low; the clock port is clk and the reset port is resetn.
  - Reset, including mid-frame, immediately forces: pad_l_y = pad_r_y = (SCREEN_H-PAD_H)/2 = 52; ball = (78,58); dir_x = right, dir_y = down; origin = (0,0); offset counters = 0.
  - Outputs after reset: x = 0, y = 0, colour = BG_COLOUR, gameover = 0.
- Strobe handling:
  - Strobes are one-hot from the FSM. If several are high, the update priority is menu > move_ball > move_pads > load_*.
  - menu (every cycle it is high): reload the reset positions and directions.
- move_pads, per paddle:
  - up & !down: y -= PAD_STEP, saturating at 0.
  - down & !up: y += PAD_STEP, saturating at SCREEN_H-PAD_H.
  - Both pressed or neither pressed: hold.
- move_ball, vertical (evaluated first):
  - dir_y = down and ball_y+BALL_SIZE == SCREEN_H: flip to up.
  - dir_y = up and ball_y == 0: flip to down.
  - Then move 1 pixel in the resulting direction.
- move_ball, horizontal:
  - overlap_L = ball_y+BALL_SIZE > pad_l_y && ball_y < pad_l_y+PAD_H. overlap_R is defined the same way against pad_r_y.
  - dir_x = left and ball_x == LEFT_PAD_X+PAD_W and overlap_L: flip to right.
  - dir_x = right and ball_x+BALL_SIZE == RIGHT_PAD_X and overlap_R: flip to left.
  - Then move 1 pixel, except the ball holds x when at an outer edge moving outward.
- gameover:
  - Combinational from registered state: (dir_x = left && ball_x == 0) || (dir_x = right && ball_x+BALL_SIZE == SCREEN_W).
  - Therefore valid in the same cycle as move_ball.
  - Clears once menu reloads positions.
- load_left_pad / load_right_pad / load_ball:
  - Latch origin = (LEFT_PAD_X, pad_l_y), (RIGHT_PAD_X, pad_r_y) or (ball_x, ball_y) respectively.
  - Latch the matching colour.
  - Paddle/ball positions sampled are those registered at that edge.
- reset_delta: off_x = off_y = 0, clr_x = clr_y = 0.
- Draw outputs:
  - Combinational, zero latency. The pixel is valid in the same cycle as the draw strobe, so the adapter captures it on the edge where plot is high.
  - Offsets advance on that same edge.
  - Output priority: clear_screen > draw_left_pad > draw_right_pad > draw_ball.
- clear_screen:
  - Outputs x = clr_x, y = clr_y, colour = BG_COLOUR.
  - clr_x increments and wraps at SCREEN_W-1 to 0, carrying into clr_y.
  - clr_y wraps at SCREEN_H-1 to 0.
  - A full sweep takes 19200 cycles.
- draw_* (shape width w, height h):
  - Outputs x = origin_x+off_x, y = origin_y+off_y, colour = latched colour.
  - off_x wraps at w-1 to 0, carrying into off_y.
  - off_y wraps at h-1 to 0, so extra cycles beyond w*h repeat from the origin.
- With no draw strobe active: x, y and the offsets hold; colour = BG_COLOUR.

Test Plan:
- Reset check: release resetn, pulse menu -> pad_l_y = pad_r_y = 52, ball (78,58), gameover = 0. Assert resetn low mid-draw_ball -> offsets 0 and colour BG asynchronously.
- Paddle saturation: hold left_up for 30 move_pads pulses -> pad_l_y steps 52,50,…,0, then stays 0. Press right_up and right_down together -> pad_r_y unchanged.
- Ball wall bounce: ball at (78,116) moving right/down, move_ball -> ball (79,115), dir_y = up.
- Paddle bounce and miss:
  - Ball (6,56) moving left, pad_l_y = 52 -> dir_x flips, ball_x = 7.
  - Same with pad_l_y = 0 -> ball reaches x = 0, then gameover = 1 on the next move_ball, ball_x holds at 0.
- Draw stream: reset_delta, load_left_pad (pad_l_y = 52), 32 draw cycles -> pixels (4,52),(5,52),(4,53)…(5,67), colour 3'b111. 33rd cycle -> (4,52).
- Clear sweep: reset_delta, then 19201 clear_screen cycles -> (0,0)…(159,0),(0,1)…(159,119), then (0,0), colour 3'b000 throughout.
